// File: rtl/grn_ctrl_pkg.sv
// Shared types and defaults for the gene-regulatory-network sweep sequencer.
// The record struct documents the layout of one attractor result at default widths.
package grn_ctrl_pkg;

  localparam int N_NODES_DEF = 8;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN_A = 3'd2,
    RUN_B = 3'd3,
    CHECK = 3'd4,
    EMIT  = 3'd5,
    DONE  = 3'd6
  } grn_state_e;

  typedef struct packed {
    logic [N_NODES_DEF-1:0] init;
    logic [N_NODES_DEF-1:0] state;
    logic [CNT_W_DEF-1:0]   steps;
    logic                   timeout;
  } grn_rec_t;

endpackage

// File: rtl/grn_sim_ctrl.sv
// Sweeps a range of initial states through the GRN node array, runs Floyd
// tortoise/hare stepping per state and reports one attractor record each.
module grn_sim_ctrl
  import grn_ctrl_pkg::*;
#(
  parameter int N_NODES = N_NODES_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_NODES-1:0] init_first,
  input  logic [N_NODES-1:0] init_last,
  input  logic [CNT_W-1:0]   max_steps,
  input  logic [N_NODES-1:0] grn_s0,
  input  logic [N_NODES-1:0] grn_s1,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_NODES-1:0] out_init,
  output logic [N_NODES-1:0] out_state,
  output logic [CNT_W-1:0]   out_steps,
  output logic               out_timeout,
  output logic               busy,
  output logic               done
);

  grn_state_e         state_q, state_d;
  logic [N_NODES-1:0] cur_init_q, cur_init_d;
  logic [N_NODES-1:0] last_q, last_d;
  logic [CNT_W-1:0]   budget_q, budget_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [N_NODES-1:0] rec_init_q, rec_init_d;
  logic [N_NODES-1:0] rec_state_q, rec_state_d;
  logic [CNT_W-1:0]   rec_steps_q, rec_steps_d;
  logic               rec_timeout_q, rec_timeout_d;
  logic               armed_q;
  logic [CNT_W-1:0]   k_inc;

  // k never exceeds budget, which is at most 2^CNT_W-1, so this cannot wrap.
  assign k_inc = k_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cur_init_q    <= '0;
      last_q        <= '0;
      budget_q      <= '0;
      k_q           <= '0;
      rec_init_q    <= '0;
      rec_state_q   <= '0;
      rec_steps_q   <= '0;
      rec_timeout_q <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_init_q    <= cur_init_d;
      last_q        <= last_d;
      budget_q      <= budget_d;
      k_q           <= k_d;
      rec_init_q    <= rec_init_d;
      rec_state_q   <= rec_state_d;
      rec_steps_q   <= rec_steps_d;
      rec_timeout_q <= rec_timeout_d;
      armed_q       <= 1'b1;
    end
  end

  // armed_q keeps a start that lands on the first edge after reset release from launching a sweep.
  always_comb begin
    state_d       = state_q;
    cur_init_d    = cur_init_q;
    last_d        = last_q;
    budget_d      = budget_q;
    k_d           = k_q;
    rec_init_d    = rec_init_q;
    rec_state_d   = rec_state_q;
    rec_steps_d   = rec_steps_q;
    rec_timeout_d = rec_timeout_q;
    case (state_q)
      IDLE: begin
        if (start && armed_q) begin
          cur_init_d = init_first;
          last_d     = init_last;
          budget_d   = (max_steps == '0) ? CNT_W'(1) : max_steps;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        k_d     = '0;
        state_d = RUN_A;
      end
      RUN_A: state_d = RUN_B;
      RUN_B: state_d = CHECK;
      CHECK: begin
        k_d = k_inc;
        if (grn_s0 == grn_s1 || k_inc == budget_q) begin
          rec_init_d    = cur_init_q;
          rec_state_d   = grn_s0;
          rec_steps_d   = k_inc;
          rec_timeout_d = (grn_s0 != grn_s1);
          state_d       = EMIT;
        end else begin
          state_d = RUN_A;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (cur_init_q == last_q) begin
            state_d = DONE;
          end else begin
            cur_init_d = cur_init_q + N_NODES'(1);
            state_d    = LOAD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign reset_nos   = (state_q == LOAD);
  assign init_state  = (state_q == LOAD) ? cur_init_q : '0;
  assign start_s0    = (state_q == RUN_A) || (state_q == RUN_B);
  assign start_s1    = (state_q == RUN_A) || (state_q == RUN_B);
  assign out_valid   = (state_q == EMIT);
  assign out_init    = rec_init_q;
  assign out_state   = rec_state_q;
  assign out_steps   = rec_steps_q;
  assign out_timeout = rec_timeout_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_grn_sim_ctrl.sv
// Randomized bench for grn_sim_ctrl: a vector-level node array plus an
// iterated-function reference model predicting every attractor record.
module tb_grn_sim_ctrl;

  localparam int NN = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NN-1:0] init_first = '0;
  logic [NN-1:0] init_last = '0;
  logic [CW-1:0] max_steps = '0;
  logic [NN-1:0] grn_s0, grn_s1;
  logic          reset_nos, start_s0, start_s1;
  logic [NN-1:0] init_state;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NN-1:0] out_init, out_state;
  logic [CW-1:0] out_steps;
  logic          out_timeout, busy, done;

  grn_sim_ctrl #(.N_NODES(NN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .init_first(init_first), .init_last(init_last), .max_steps(max_steps),
    .grn_s0(grn_s0), .grn_s1(grn_s1),
    .reset_nos(reset_nos), .init_state(init_state),
    .start_s0(start_s0), .start_s1(start_s1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_init(out_init), .out_state(out_state), .out_steps(out_steps),
    .out_timeout(out_timeout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int modeSel = 0;
  logic [NN-1:0] lut [16];

  typedef struct {
    logic [NN-1:0] init;
    logic [NN-1:0] state;
    int            steps;
    bit            timeout;
  } expRec_t;
  expRec_t expQ[$];

  function automatic logic [NN-1:0] fnext(input logic [NN-1:0] x);
    case (modeSel)
      0:       return x;
      1:       return x + NN'(1);
      default: return lut[x];
    endcase
  endfunction

  function automatic logic [NN-1:0] iterate(input logic [NN-1:0] x, input int n);
    logic [NN-1:0] v = x;
    for (int i = 0; i < n; i++) v = fnext(v);
    return v;
  endfunction

  // Node array: s1 moves on every strobe, s0 on every second strobe after a load.
  logic [NN-1:0] nodeS0 = '0, nodeS1 = '0;
  logic          phase = 1'b0;
  assign grn_s0 = nodeS0;
  assign grn_s1 = nodeS1;

  always @(posedge clk) begin
    if (reset_nos) begin
      nodeS0 <= init_state;
      nodeS1 <= init_state;
      phase  <= 1'b0;
    end else begin
      if (start_s1) nodeS1 <= fnext(nodeS1);
      if (start_s0) begin
        if (phase) nodeS0 <= fnext(nodeS0);
        phase <= ~phase;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic buildExpected(input logic [NN-1:0] first, input logic [NN-1:0] last, input logic [CW-1:0] ms);
    logic [NN-1:0] x = first;
    int budget = (ms == 0) ? 1 : int'(ms);
    expQ.delete();
    forever begin
      expRec_t r;
      r.init = x;
      for (int k = 1; k <= budget; k++) begin
        logic [NN-1:0] t = iterate(x, k);
        logic [NN-1:0] h = iterate(x, 2 * k);
        if (t == h || k == budget) begin
          r.state = t;
          r.steps = k;
          r.timeout = (t != h);
          break;
        end
      end
      expQ.push_back(r);
      if (x == last) break;
      x = x + NN'(1);
    end
  endtask

  // Called on a falling edge; returns on the falling edge where the sweep sits in LOAD.
  task automatic applyStimulus(input logic [NN-1:0] first, input logic [NN-1:0] last, input logic [CW-1:0] ms);
    init_first = first;
    init_last  = last;
    max_steps  = ms;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic runSweep(input int mode, input logic [NN-1:0] first, input logic [NN-1:0] last,
                          input logic [CW-1:0] ms, input int stall);
    int cyc = 0, loadCyc = 0, waitCnt = 0;
    bit inEmit = 0, lastHs = 0, finished = 0, rdy;
    logic [NN-1:0] hInit, hState;
    logic [CW-1:0] hSteps;
    logic hTo;
    modeSel = mode;
    buildExpected(first, last, ms);
    applyStimulus(first, last, ms);
    checkOutput("load_busy", busy, 1);
    checkOutput("load_first_init", init_state, first);
    while (!finished && cyc < 5000) begin
      if (reset_nos) loadCyc = cyc;
      if (out_valid) begin
        if (!inEmit) begin
          inEmit  = 1;
          waitCnt = 0;
          checkOutput("rec_init", out_init, expQ[0].init);
          checkOutput("rec_state", out_state, expQ[0].state);
          checkOutput("rec_steps", out_steps, expQ[0].steps);
          checkOutput("rec_timeout", out_timeout, expQ[0].timeout);
          checkOutput("rec_latency", cyc - loadCyc, 1 + 3 * expQ[0].steps);
          hInit = out_init; hState = out_state; hSteps = out_steps; hTo = out_timeout;
        end else begin
          checkOutput("hold_record", {out_init, out_state, out_steps, out_timeout},
                      {hInit, hState, hSteps, hTo});
          checkOutput("hold_no_strobes", {reset_nos, start_s0, start_s1}, 0);
        end
        rdy = (stall >= 0) ? (waitCnt >= stall) : ($urandom_range(3) == 0);
        out_ready = rdy;
        waitCnt++;
        if (rdy) begin
          void'(expQ.pop_front());
          inEmit = 0;
          if (expQ.size() == 0) lastHs = 1;
        end
      end else begin
        out_ready = 1'b0;
      end
      // A start pulse mid-sweep must not disturb the running sweep.
      if (cyc == 3) begin
        start      = 1'b1;
        init_first = NN'($urandom);
        init_last  = NN'($urandom);
        max_steps  = CW'($urandom_range(1, 3));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (lastHs) begin
        out_ready = 1'b0;
        checkOutput("done_pulse", done, 1);
        checkOutput("valid_after_last", out_valid, 0);
        @(negedge clk);
        checkOutput("idle_after_done", busy, 0);
        checkOutput("done_single", done, 0);
        finished = 1;
      end
    end
    out_ready = 1'b0;
    start = 1'b0;
    checkOutput("sweep_finished", finished, 1);
    checkOutput("records_left", expQ.size(), 0);
  endtask

  task automatic resetMidRun();
    modeSel = 1;
    applyStimulus(4'h0, 4'h0, 16'd20);
    @(negedge clk);
    checkOutput("runa_step", start_s0, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_s0", start_s0, 0);
    checkOutput("async_s1", start_s1, 0);
    checkOutput("async_busy", busy, 0);
    checkOutput("async_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_at_release", busy, 0);
  endtask

  initial begin
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_strobes", {reset_nos, start_s0, start_s1}, 0);
    checkOutput("rst_record", {out_init, out_state, out_steps, out_timeout}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_at_release", busy, 0);
    @(negedge clk);

    runSweep(0, 4'h5, 4'h5, 16'd8, 0);
    runSweep(1, 4'h0, 4'h0, 16'd20, 0);
    runSweep(1, 4'h0, 4'h0, 16'd10, 0);
    runSweep(1, 4'h0, 4'h0, 16'd0, 0);
    runSweep(0, 4'hE, 4'h1, 16'd8, 0);
    runSweep(0, 4'h3, 4'h3, 16'd4, 5);

    for (int i = 0; i < 16; i++) lut[i] = NN'($urandom);
    for (int n = 0; n < 6; n++) begin
      logic [NN-1:0] f = NN'($urandom);
      runSweep(2, f, f + NN'($urandom_range(0, 3)), CW'($urandom_range(0, 25)), -1);
    end

    resetMidRun();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
